// File: rtl/sha2_pkg.sv
// ----------------------------------------------------------------------------
// sha2_pkg
// Shared constants and helper functions for the SHA-224/SHA-256 compression
// engine: the 64-entry round-constant table, both initial hash values, the
// sigma/choose/majority functions and the engine's state enumeration.
// No ports; imported by sha2_compress and sha2_wschedule.
// ----------------------------------------------------------------------------
package sha2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROUND,
      ST_FINAL,
      ST_DONE
   } sha2_state_t;

   // Ascending packed index so that IV_*[i] is Hi and K_TABLE[t] is K[t].
   localparam logic [0:7][31:0] IV_SHA256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [0:7][31:0] IV_SHA224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   localparam logic [0:63][31:0] K_TABLE = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] k_word(input logic [5:0] t);
      return K_TABLE[t];
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                      input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha2_wschedule.sv
// ----------------------------------------------------------------------------
// sha2_wschedule
// SHA-2 message schedule as a 16-word sliding window. The window always holds
// W[t] .. W[t+15] for the next round t to be executed.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : parallel-load block_in into the window (W0 = [511:480])
//   advance      : slide the window forward by UNROLL words
//   block_in     : 512-bit padded message block
//   w_out        : W[t] .. W[t+UNROLL-1], word i at [32*i +: 32]
// ----------------------------------------------------------------------------
module sha2_wschedule
   import sha2_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic                  advance,
   input  logic [511:0]          block_in,
   output logic [UNROLL*32-1:0]  w_out
);

   logic [31:0] win       [16];
   logic [31:0] win_next  [16];
   logic [31:0] blk_words [16];
   logic [31:0] w_words   [UNROLL];

   for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
      assign blk_words[gi] = block_in[511-32*gi -: 32];
   end

   for (genvar gi = 0; gi < UNROLL; gi++) begin : g_pack
      assign w_out[32*gi +: 32] = w_words[gi];
   end

   // Extend the window by UNROLL freshly expanded words. The expansion is
   // applied uniformly: while t < 16 the window still holds the loaded words,
   // and the extra words computed beyond it are exactly W[16..] as they will
   // be needed, so no special case for the first sixteen rounds is required.
   always_comb begin
      logic [31:0] ext [16+UNROLL];
      for (int j = 0; j < 16; j++) begin
         ext[j] = win[j];
      end
      for (int j = 16; j < 16 + UNROLL; j++) begin
         ext[j] = small_sigma1(ext[j-2]) + ext[j-7] + small_sigma0(ext[j-15]) + ext[j-16];
      end
      for (int j = 0; j < UNROLL; j++) begin
         w_words[j] = ext[j];
      end
      for (int j = 0; j < 16; j++) begin
         win_next[j] = ext[j+UNROLL];
      end
   end

   // The window is loaded in parallel when a block is accepted and slides
   // by UNROLL words on every round cycle; otherwise it simply holds.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win <= '{default: '0};
      end else if (load) begin
         win <= blk_words;
      end else if (advance) begin
         win <= win_next;
      end
   end

endmodule

// File: rtl/sha2_compress.sv
// ----------------------------------------------------------------------------
// sha2_compress
// SHA-224/SHA-256 compression engine running UNROLL rounds per clock, with
// feed-forward into the chaining state. The digest is held until the next
// block is accepted.
//   clk, reset_n  : clock, asynchronous active-low reset
//   block_in      : 512-bit padded block, W0 = [511:480]
//   block_valid   : block_in valid
//   block_ready   : engine idle or done, can accept a block
//   first         : with the block: 1 loads the IV, 0 chains from current H
//   mode_224      : with a first block: 1 = SHA-224 IV, 0 = SHA-256 IV
//   digest        : H0 = [255:224] .. H7 = [31:0]; [31:0] reads 0 in SHA-224
//   digest_valid  : digest valid
// ----------------------------------------------------------------------------
module sha2_compress
   import sha2_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [511:0] block_in,
   input  logic         block_valid,
   output logic         block_ready,
   input  logic         first,
   input  logic         mode_224,
   output logic [255:0] digest,
   output logic         digest_valid
);

   if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
      $error("sha2_compress: UNROLL must be 1, 2, 4 or 8");
   end

   sha2_state_t state;
   sha2_state_t state_next;

   logic [6:0]            cnt;
   logic                  mode_q;
   logic                  accept;
   logic                  last_round;
   logic [31:0]           h_reg   [8];
   logic [31:0]           wv      [8];
   logic [31:0]           wv_next [8];
   logic [31:0]           iv_sel  [8];
   logic [31:0]           h_sum   [8];
   logic [31:0]           w_word  [UNROLL];
   logic [UNROLL*32-1:0]  w_flat;
   logic [255:0]          h_flat;

   assign accept     = block_valid && block_ready;
   assign last_round = (cnt + 7'(UNROLL)) == 7'd64;

   for (genvar gi = 0; gi < 8; gi++) begin : g_words
      assign iv_sel[gi]                 = mode_224 ? IV_SHA224[gi] : IV_SHA256[gi];
      assign h_sum[gi]                  = h_reg[gi] + wv[gi];
      assign h_flat[255-32*gi -: 32]    = h_reg[gi];
   end

   for (genvar gi = 0; gi < UNROLL; gi++) begin : g_wsplit
      assign w_word[gi] = w_flat[32*gi +: 32];
   end

   sha2_wschedule #(
      .UNROLL(UNROLL)
   ) u_wschedule (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (accept),
      .advance  (state == ST_ROUND),
      .block_in (block_in),
      .w_out    (w_flat)
   );

   // UNROLL chained copies of the round function. Each copy consumes the
   // working variables left by the previous one, so one clock covers rounds
   // cnt .. cnt+UNROLL-1 with their matching K and W words.
   always_comb begin
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      a  = wv[0];
      b  = wv[1];
      c  = wv[2];
      d  = wv[3];
      e  = wv[4];
      f  = wv[5];
      g  = wv[6];
      h  = wv[7];
      t1 = '0;
      t2 = '0;
      for (int i = 0; i < UNROLL; i++) begin
         t1 = h + big_sigma1(e) + ch(e, f, g) + k_word(cnt[5:0] + 6'(i)) + w_word[i];
         t2 = big_sigma0(a) + maj(a, b, c);
         h  = g;
         g  = f;
         f  = e;
         e  = d + t1;
         d  = c;
         c  = b;
         b  = a;
         a  = t1 + t2;
      end
      wv_next[0] = a;
      wv_next[1] = b;
      wv_next[2] = c;
      wv_next[3] = d;
      wv_next[4] = e;
      wv_next[5] = f;
      wv_next[6] = g;
      wv_next[7] = h;
   end

   // State register for the IDLE -> ROUND -> FINAL -> DONE sequence.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. A block is taken only from IDLE or DONE; after the
   // last group of rounds a single FINAL cycle performs the feed-forward.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE: if (accept) state_next = ST_ROUND;
         ST_ROUND:         if (last_round) state_next = ST_FINAL;
         ST_FINAL:         state_next = ST_DONE;
         default:          state_next = ST_IDLE;
      endcase
   end

   // Outputs decode only the state register, so nothing here depends
   // combinationally on block_valid. The digest is shown only in DONE and
   // its last word is blanked when the latched mode is SHA-224.
   always_comb begin
      block_ready  = (state == ST_IDLE) || (state == ST_DONE);
      digest_valid = (state == ST_DONE);
      digest       = '0;
      if (state == ST_DONE) begin
         digest = mode_q ? {h_flat[255:32], 32'h0} : h_flat;
      end
   end

   // Datapath registers. On acceptance the working variables start from
   // either the selected IV (which also becomes H) or the current H; each
   // round cycle advances them, and FINAL folds them back into H.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_reg  <= '{default: '0};
         wv     <= '{default: '0};
         cnt    <= '0;
         mode_q <= 1'b0;
      end else begin
         if (accept) begin
            cnt <= '0;
            if (first) begin
               h_reg  <= iv_sel;
               wv     <= iv_sel;
               mode_q <= mode_224;
            end else begin
               wv <= h_reg;
            end
         end else if (state == ST_ROUND) begin
            wv  <= wv_next;
            cnt <= cnt + 7'(UNROLL);
         end else if (state == ST_FINAL) begin
            h_reg <= h_sum;
         end
      end
   end

endmodule
